uart_rx_frame: RTL and testbench

//  Serial UART receiver. It is the downstream partner of the TxTop transmitter and decodes its out_data line back into parallel bytes.

---
 rtl/uart_rx_frame.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receiver: 2-FF input sync, 16x oversampled mid-bit sampling,
// 7/8 data bits, optional odd/even parity, 1/2 stop bits, error flags.
module uart_rx_frame #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_serial,
    input  logic [1:0] bd_rate,
    input  logic [1:0] para,
    input  logic       s_num,
    input  logic       d_num,
    output logic [7:0] out_data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV_1200 = CLK_FREQ / (1200 * OVERSAMPLE);
    localparam int DIV_2400 = CLK_FREQ / (2400 * OVERSAMPLE);
    localparam int DIV_4800 = CLK_FREQ / (4800 * OVERSAMPLE);
    localparam int DIV_9600 = CLK_FREQ / (9600 * OVERSAMPLE);
    localparam int DW = $clog2(DIV_1200 + 1);
    localparam int TW = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic          sync1;
    logic          rx_s;
    logic [1:0]    cfg_bd;
    logic [1:0]    cfg_para;
    logic          cfg_s;
    logic          cfg_d;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_last;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          smp;
    logic [2:0]    bit_idx;
    logic [2:0]    last_bit;
    logic [7:0]    shift;
    logic          par_acc;
    logic          pe_r;
    logic          fe_r;
    logic          has_par;
    logic          done;
    logic          fe_now;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= in_serial;
            rx_s  <= sync1;
        end
    end

    always_comb begin
        div_last = DW'(DIV_1200 - 1);
        unique case (cfg_bd)
            2'b00: div_last = DW'(DIV_1200 - 1);
            2'b01: div_last = DW'(DIV_2400 - 1);
            2'b10: div_last = DW'(DIV_4800 - 1);
            2'b11: div_last = DW'(DIV_9600 - 1);
        endcase
    end

    // Held at zero in IDLE so the first tick lands a full divisor after START entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick = (state != IDLE) && (div_cnt == div_last);

    assign smp = tick && ((state == START) ? (tick_cnt == T_MID)
                                           : (tick_cnt == T_END));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (state == IDLE || smp) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign last_bit = cfg_d ? 3'd7 : 3'd6;
    assign has_par  = cfg_para[0] ^ cfg_para[1];
    assign fe_now   = ~rx_s | ((state == STOP2) & fe_r);
    assign done     = smp && ((state == STOP2) ||
                              (state == STOP1 && !cfg_s));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cfg_bd     <= 2'b00;
            cfg_para   <= 2'b00;
            cfg_s      <= 1'b0;
            cfg_d      <= 1'b0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            par_acc    <= 1'b0;
            pe_r       <= 1'b0;
            fe_r       <= 1'b0;
            out_data   <= 8'h00;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        cfg_bd   <= bd_rate;
                        cfg_para <= para;
                        cfg_s    <= s_num;
                        cfg_d    <= d_num;
                    end
                end
                START: begin
                    if (smp) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            busy    <= 1'b1;
                            bit_idx <= 3'd0;
                            shift   <= 8'h00;
                            par_acc <= 1'b0;
                            pe_r    <= 1'b0;
                            fe_r    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (smp) begin
                        shift[bit_idx] <= rx_s;
                        par_acc        <= par_acc ^ rx_s;
                        if (bit_idx == last_bit) begin
                            state <= has_par ? PARITY : STOP1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (smp) begin
                        pe_r  <= (cfg_para == 2'b01) ? ~(par_acc ^ rx_s)
                                                     : (par_acc ^ rx_s);
                        state <= STOP1;
                    end
                end
                STOP1: begin
                    if (smp && cfg_s) begin
                        fe_r  <= ~rx_s;
                        state <= STOP2;
                    end
                end
                STOP2: begin
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A zero stop bit may be a break, so hold off until the line idles
            if (done) begin
                out_data   <= shift;
                data_valid <= 1'b1;
                parity_err <= pe_r;
                frame_err  <= fe_now;
                busy       <= 1'b0;
                state      <= fe_now ? WAIT_HIGH : IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: vector table plus hand sequences, with a
// queue scoreboard checked whenever data_valid fires.
module tb_uart_rx_frame;

    localparam int CLK_FREQ = 768_000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_serial = 1'b1;
    logic [1:0] bd_rate = 2'b00;
    logic [1:0] para = 2'b00;
    logic       s_num = 1'b0;
    logic       d_num = 1'b0;
    logic [7:0] out_data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(16)) dut (
        .clk(clk),
        .rst(rst),
        .in_serial(in_serial),
        .bd_rate(bd_rate),
        .para(para),
        .s_num(s_num),
        .d_num(d_num),
        .out_data(out_data),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [1:0] bd;
        logic [1:0] pa;
        logic       s;
        logic       d;
        logic [7:0] data;
        logic       flip;
        logic [1:0] sbad;
        logic       hold;
        logic [7:0] xd;
        logic       xpe;
        logic       xfe;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[10];
    int   nvec = 0;
    int   nmis = 0;
    logic busy_seen = 1'b0;
    logic quiet_rep = 1'b0;

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
        end
    endtask

    function automatic int bitclk(logic [1:0] bd);
        return 16 * (CLK_FREQ / ((1200 << bd) * 16));
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (rst && data_valid) begin
            if (sbq.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL unexpected_valid: got data 0x%h, want none",
                         out_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_data", out_data, e.d);
                chk("parity_err", {7'b0, parity_err}, {7'b0, e.pe});
                chk("frame_err", {7'b0, frame_err}, {7'b0, e.fe});
            end
        end else if (rst && (parity_err || frame_err) && !quiet_rep) begin
            quiet_rep = 1'b1;
            nmis++;
            $display("FAIL flags_unqualified: got pe=%b fe=%b, want 0 0",
                     parity_err, frame_err);
        end
    end

    task automatic drive_bit(logic v, int n);
        in_serial = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(logic [1:0] bd, logic [1:0] pa, logic s,
                              logic d, logic [7:0] data, logic flip,
                              logic [1:0] sbad, logic hold);
        int bc;
        logic [7:0] m;
        logic p;
        bd_rate = bd;
        para = pa;
        s_num = s;
        d_num = d;
        bc = bitclk(bd);
        m = d ? data : {1'b0, data[6:0]};
        p = ((pa == 2'b01) ? ~^m : ^m) ^ flip;
        drive_bit(1'b0, bc);
        for (int i = 0; i < (d ? 8 : 7); i++) drive_bit(data[i], bc);
        if (pa == 2'b01 || pa == 2'b10) drive_bit(p, bc);
        drive_bit(~sbad[0], bc);
        if (s) drive_bit(~sbad[1], bc);
        if (!hold) in_serial = 1'b1;
    endtask

    task automatic push(logic [7:0] d, logic pe, logic fe);
        exp_t e;
        e.d = d;
        e.pe = pe;
        e.fe = fe;
        sbq.push_back(e);
    endtask

    task automatic drain(string nm);
        int k = 0;
        while (sbq.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            nmis++;
            $display("FAIL %s_timeout: got %0d pending, want 0", nm,
                     sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        //          bd    pa   s  d  data   fl sbad hd  xd    pe fe
        vecs[0] = '{2'b00, 2'b00, 0, 0, 8'h2D, 0, 2'b00, 0, 8'h2D, 0, 0};
        vecs[1] = '{2'b01, 2'b01, 1, 1, 8'hA5, 0, 2'b00, 0, 8'hA5, 0, 0};
        vecs[2] = '{2'b01, 2'b01, 1, 1, 8'hA5, 1, 2'b00, 0, 8'hA5, 1, 0};
        vecs[3] = '{2'b10, 2'b10, 0, 1, 8'h00, 0, 2'b01, 1, 8'h00, 0, 1};
        vecs[4] = '{2'b11, 2'b00, 0, 0, 8'hFF, 0, 2'b00, 0, 8'h7F, 0, 0};
        vecs[5] = '{2'b11, 2'b10, 1, 1, 8'h81, 0, 2'b00, 0, 8'h81, 0, 0};
        vecs[6] = '{2'b01, 2'b01, 0, 0, 8'h40, 1, 2'b00, 0, 8'h40, 1, 0};
        vecs[7] = '{2'b11, 2'b11, 1, 1, 8'hC3, 0, 2'b00, 0, 8'hC3, 0, 0};
        vecs[8] = '{2'b11, 2'b10, 0, 0, 8'h35, 0, 2'b00, 0, 8'h35, 0, 0};
        vecs[9] = '{2'b11, 2'b00, 1, 1, 8'h3C, 0, 2'b10, 0, 8'h3C, 0, 1};

        repeat (3) @(negedge clk);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_valid", {7'b0, data_valid}, 8'h00);
        chk("rst_perr", {7'b0, parity_err}, 8'h00);
        chk("rst_ferr", {7'b0, frame_err}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            vec_t v;
            v = vecs[i];
            push(v.xd, v.xpe, v.xfe);
            send_frame(v.bd, v.pa, v.s, v.d, v.data, v.flip, v.sbad, v.hold);
            drain($sformatf("vec%0d", i));
            if (v.hold) begin
                repeat (3 * bitclk(v.bd)) @(negedge clk);
                chk("wait_high_busy", {7'b0, busy}, 8'h00);
                in_serial = 1'b1;
                repeat (bitclk(v.bd)) @(negedge clk);
            end
            repeat (20) @(negedge clk);
        end

        // Short low glitch at 9600 must be rejected
        bd_rate = 2'b11;
        para = 2'b00;
        s_num = 1'b0;
        d_num = 1'b1;
        busy_seen = 1'b0;
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 80);
        chk("glitch_busy", {7'b0, busy_seen}, 8'h00);
        push(8'h55, 0, 0);
        push(8'hAA, 0, 0);
        send_frame(2'b11, 2'b00, 0, 1, 8'h55, 0, 2'b00, 0);
        send_frame(2'b11, 2'b00, 0, 1, 8'hAA, 0, 2'b00, 0);
        drain("b2b");
        repeat (20) @(negedge clk);

        // Reset in the middle of DATA
        bd_rate = 2'b00;
        para = 2'b00;
        s_num = 1'b0;
        d_num = 1'b1;
        drive_bit(1'b0, bitclk(2'b00));
        drive_bit(1'b0, 3 * bitclk(2'b00));
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_out_data", out_data, 8'h00);
        chk("mid_rst_valid", {7'b0, data_valid}, 8'h00);
        chk("mid_rst_busy", {7'b0, busy}, 8'h00);
        chk("mid_rst_perr", {7'b0, parity_err}, 8'h00);
        chk("mid_rst_ferr", {7'b0, frame_err}, 8'h00);
        in_serial = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        push(8'h3C, 0, 0);
        send_frame(2'b11, 2'b00, 0, 1, 8'h3C, 0, 2'b00, 0);
        drain("post_rst");
        repeat (20) @(negedge clk);

        // Config change mid-frame only affects the following frame
        push(8'h96, 0, 0);
        fork
            send_frame(2'b10, 2'b10, 0, 1, 8'h96, 0, 2'b00, 0);
            begin
                repeat (3 * bitclk(2'b10)) @(negedge clk);
                bd_rate = 2'b11;
                para = 2'b00;
                s_num = 1'b1;
                d_num = 1'b0;
            end
        join
        drain("cfg_old");
        repeat (20) @(negedge clk);
        push(8'h5A, 0, 0);
        send_frame(2'b11, 2'b00, 1, 0, 8'hDA, 0, 2'b00, 0);
        drain("cfg_new");
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
